// File: rtl/booth_product_accumulator.sv
// Signed product accumulator (dot-product back end) with valid/ready in and out.
// Define ACC_SATURATE_EN to clamp on overflow instead of wrapping; Acc_Width must be >= Product_Width.
module booth_product_accumulator #(
  parameter int Product_Width = 16,
  parameter int Acc_Width     = 24,
  parameter int Count_Width   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [Count_Width-1:0]   length,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [Product_Width-1:0] in_product,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [Acc_Width-1:0]     out_sum,
  output logic                     out_overflow,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  localparam logic [Acc_Width-1:0] AccMax = {1'b0, {(Acc_Width-1){1'b1}}};
  localparam logic [Acc_Width-1:0] AccMin = {1'b1, {(Acc_Width-1){1'b0}}};

  state_e                     state_q;
  logic [Acc_Width-1:0]       acc_q;
  logic [Acc_Width-1:0]       acc_d;
  logic [Count_Width-1:0]     cnt_q;
  logic                       ovf_q;
  logic                       in_ready_q;
  logic                       out_valid_q;
  logic                       busy_q;

  logic signed [Product_Width-1:0] prod_s;
  logic [Acc_Width-1:0]            prod_ext;
  logic [Acc_Width-1:0]            sum_raw;
  logic                            add_ovf;

  // Size cast of a signed operand sign-extends the product to the accumulator width.
  assign prod_s   = $signed(in_product);
  assign prod_ext = Acc_Width'(prod_s);
  assign sum_raw  = acc_q + prod_ext;
  assign add_ovf  = (acc_q[Acc_Width-1] == prod_ext[Acc_Width-1]) &&
                    (sum_raw[Acc_Width-1] != acc_q[Acc_Width-1]);

  always_comb begin
    // NOTE: default assignment first so every path drives acc_d and no latch is inferred.
    acc_d = sum_raw;
`ifdef ACC_SATURATE_EN
    if (add_ovf) begin
      acc_d = acc_q[Acc_Width-1] ? AccMin : AccMax;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            cnt_q  <= length;
            busy_q <= 1'b1;
            if (length == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q    <= ACCUM;
              in_ready_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | add_ovf;
            cnt_q <= cnt_q - 1'b1;
            // Last product of the run: hand off to the output side.
            if (cnt_q == Count_Width'(1)) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign out_sum      = acc_q;
  assign out_overflow = ovf_q;

endmodule

// File: doc/booth_product_accumulator.md
# booth_product_accumulator

Sequential accumulator that sits directly downstream of the combinational 8×8 signed Booth multiplier and consumes its 16-bit two's-complement products. It sums a programmed number of products (a fixed-point dot product), one per clock under a valid/ready handshake, and presents the wide signed result with an overflow flag on a second valid/ready handshake.

## Interface
- `Product_Width`, 16, width of the signed product input (multiplier output width)
- `Acc_Width`, 24, width of the signed accumulator and result; must be ≥ `Product_Width`
- `Count_Width`, 8, width of the length input; the maximum run is 2^`Count_Width` − 1 products

Ports:
- `clk`  input  1  clock; all state changes on the rising edge
- `rst`  input  1  reset; **synchronous, active-high**
- `start`  input  1  begins a run; sampled only in IDLE
- `length`  input  `Count_Width`  number of products in the run; latched when `start` is accepted
- `in_valid`  input  1  `in_product` is valid
- `in_ready`  output  1  block accepts a product this cycle
- `in_product`  input  `Product_Width`  signed product from the multiplier
- `out_valid`  output  1  `out_sum` and `out_overflow` are valid
- `out_ready`  input  1  consumer takes the result
- `out_sum`  output  `Acc_Width`  signed accumulated result
- `out_overflow`  output  1  sticky flag: at least one addition in the run overflowed `Acc_Width`
- `busy`  output  1  high whenever the state is not IDLE

## Operation
- The FSM has three states: IDLE, ACCUM and DONE.
- **IDLE:**
  - `start` = 1 clears the accumulator and the overflow flag and latches `length` into the remaining counter.
  - If `length` = 0, the next state is DONE with a sum of 0. Otherwise the next state is ACCUM.
- **ACCUM:**
  - `in_ready` = 1.
  - On each cycle with `in_valid` && `in_ready`:
    - `in_product` is sign-extended to `Acc_Width` and added to the accumulator.
    - The counter decrements.
  - When the counter reaches 0 on that accept, the next state is DONE.
  - Cycles without `in_valid` are stalls; state is held.
- **DONE:**
  - `out_valid` = 1; `out_sum` equals the accumulator and is stable while `out_valid` is high.
  - When `out_ready` = 1, the next state is IDLE.
- **Overflow on an addition:** both operands have the same sign and the result sign differs. This sets `out_overflow` and it stays set until the next accepted `start`.
- `start` outside IDLE is ignored; it is neither queued nor restarts the run.
- `in_ready` = 0 in IDLE and DONE. Products offered in those states are not consumed.

## Timing
- **Reset values:** state = IDLE, `in_ready` = 0, `out_valid` = 0, `out_sum` = 0, `out_overflow` = 0, `busy` = 0, counter = 0.
- `rst` takes effect at the next edge from any state and abandons a run in progress. `rst` has priority over every other input.
- **Throughput:** one product per cycle when `in_valid` is held high.
- **Latency:**
  - `out_valid` rises on the edge after the clock edge that accepts the last product.
  - For `length` = 0, `out_valid` rises 1 cycle after `start`.
  - For `length` = N with `in_valid` continuously high, `out_valid` rises N+1 cycles after `start`.
- **DONE to IDLE:**
  - `out_valid` drops on the edge where `out_ready` is sampled high.
  - A `start` is accepted no earlier than the following cycle.
  - There is no same-cycle DONE→ACCUM bypass.
- **Outputs:** all outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- **Macro:** `ACC_SATURATE_EN`.
- **Defined:** every addition saturates.
  - A positive overflow clamps the accumulator to 2^(`Acc_Width`−1) − 1.
  - A negative overflow clamps it to −2^(`Acc_Width`−1).
  - Later additions continue from the clamped value.
  - `out_overflow` is still set.
- **Undefined:** additions wrap modulo 2^`Acc_Width`. `out_overflow` reports the wrap.

## Test plan
- **Reset:** assert `rst` for 2 cycles. Required: all outputs 0 and `busy` = 0.
- **Basic run:**
  - Stimulus: `length` = 3, products 0x3F01 (16129), 0xC0FF (−16129), 0x0010 (16), `in_valid` held high.
  - Required: `out_valid` 4 cycles after `start`, `out_sum` = 0x000010, `out_overflow` = 0.
- **Stalls and back-pressure:**
  - Stimulus: `length` = 2, `in_valid` toggled 1,0,0,1 with products −64 and −64; `out_ready` held low for 3 cycles.
  - Required: `out_sum` = 0xFFFF80, held stable until `out_ready`; no product consumed in DONE.
- **Zero length, ignored start, mid-run reset:**
  - `length` = 0: required `out_sum` = 0 one cycle after `start`.
  - `start` pulsed during ACCUM: required to be ignored.
  - `rst` asserted mid-run: required to return to IDLE with `out_valid` = 0.
- **Overflow:**
  - Stimulus: `Acc_Width` = 17, `length` = 3, products 0x7FFF ×3.
  - Without `ACC_SATURATE_EN`: required `out_sum` = 0x17FFD (wrapped, reads as −32771), `out_overflow` = 1.
  - With `ACC_SATURATE_EN`: required `out_sum` = 0x0FFFF, `out_overflow` = 1.
- **Chained with the multiplier:**
  - Stimulus: multiplier operand pairs (−128, −128), (127, −128), (5, −3).
  - Required: `out_sum` = 16384 − 16256 − 15 = 113.
